mcs_io_bridge_fsm: RTL and testbench

MCS_IO_BRIDGE_FSM -- requirements
Module: mcs_io_bridge_fsm

---
 rtl/mcs_io_bridge_fsm.sv | 174 +++++++++++++++++
 tb/tb_mcs_io_bridge_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mcs_io_bridge_fsm.sv
// MicroBlaze MCS I/O bus to FPro video/MMIO bridge; optional byte-lane RMW via BRG_BYTE_MERGE_EN.
// Latency: write hit ready in cycle 2, read hit ready in cycle 2+RD_LAT, miss or empty-be ready in cycle 1.
// Backpressure: one transaction in flight; strobes arriving outside IDLE are dropped.
module mcs_io_bridge_fsm #(
    parameter logic [31:0] BRG_BASE = 32'hc000_0000,
    parameter int          RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        fp_video_cs,
    output logic        fp_mmio_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [20:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] fp_rd_data
);

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, ACK} state_t;

    // RWAIT spans the whole fp_rd_data latency so the sample lands RD_LAT cycles after fp_rd.
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        video_q, video_d;
    logic [20:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fp_wr_q, fp_rd_q, video_cs_q, mmio_cs_q, ready_q;
    logic        hit;
    logic        unused_addr_bits;

    assign hit              = (io_address[31:24] == BRG_BASE[31:24]);
    assign unused_addr_bits = ^io_address[1:0];

`ifdef BRG_BYTE_MERGE_EN
    logic [3:0]  be_q, be_d;
    logic        rmw_q, rmw_d;
    logic [31:0] merged;

    always_comb begin
        merged = fp_rd_data;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        video_d = video_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef BRG_BYTE_MERGE_EN
        be_d    = be_q;
        rmw_d   = rmw_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (io_addr_strobe && (io_write_strobe || io_read_strobe)) begin
                    addr_d  = io_address[22:2];
                    video_d = io_address[23];
                    wdata_d = io_write_data;
`ifdef BRG_BYTE_MERGE_EN
                    be_d    = io_byte_enable;
                    rmw_d   = 1'b0;
`endif
                    if (io_write_strobe) begin
                        if (!hit || io_byte_enable == 4'h0) begin
                            state_d = ACK;
                        end
`ifdef BRG_BYTE_MERGE_EN
                        else if (io_byte_enable != 4'hf) begin
                            rmw_d   = 1'b1;
                            state_d = RD;
                        end
`endif
                        else begin
                            state_d = WR;
                        end
                    end else if (!hit) begin
                        rdata_d = 32'h0000_0000;
                        state_d = ACK;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                cnt_d   = CNT_INIT;
                state_d = RWAIT;
            end
            RWAIT: begin
                if (cnt_q == 2'd0) begin
`ifdef BRG_BYTE_MERGE_EN
                    if (rmw_q) begin
                        wdata_d = merged;
                        state_d = WR;
                    end else begin
                        rdata_d = fp_rd_data;
                        state_d = ACK;
                    end
`else
                    rdata_d = fp_rd_data;
                    state_d = ACK;
`endif
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WR:      state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from the next state so every pulse is glitch-free and aligned with its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            video_q    <= 1'b0;
            addr_q     <= 21'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            fp_wr_q    <= 1'b0;
            fp_rd_q    <= 1'b0;
            video_cs_q <= 1'b0;
            mmio_cs_q  <= 1'b0;
            ready_q    <= 1'b0;
`ifdef BRG_BYTE_MERGE_EN
            be_q       <= 4'h0;
            rmw_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            video_q    <= video_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fp_wr_q    <= (state_d == WR);
            fp_rd_q    <= (state_d == RD);
            video_cs_q <= ((state_d == WR) || (state_d == RD)) && video_d;
            mmio_cs_q  <= ((state_d == WR) || (state_d == RD)) && !video_d;
            ready_q    <= (state_d == ACK);
`ifdef BRG_BYTE_MERGE_EN
            be_q       <= be_d;
            rmw_q      <= rmw_d;
`endif
        end
    end

    assign io_read_data = rdata_q;
    assign io_ready     = ready_q;
    assign fp_video_cs  = video_cs_q;
    assign fp_mmio_cs   = mmio_cs_q;
    assign fp_wr        = fp_wr_q;
    assign fp_rd        = fp_rd_q;
    assign fp_addr      = addr_q;
    assign fp_wr_data   = wdata_q;

endmodule

// File: tb/tb_mcs_io_bridge_fsm.sv
// Drives one DUT with RD_LAT=1 and one with RD_LAT=3 in lockstep from a vector table plus reset/abort sequences.
module tb_mcs_io_bridge_fsm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_addr_strobe = 1'b0;
    logic        io_read_strobe = 1'b0;
    logic        io_write_strobe = 1'b0;
    logic [3:0]  io_byte_enable = 4'h0;
    logic [31:0] io_address = 32'h0;
    logic [31:0] io_write_data = 32'h0;
    logic [31:0] mem_val = 32'h0;

    logic [1:0][31:0] rdat, fwd, frdat;
    logic [1:0][20:0] fad;
    logic [1:0]       rdy, vcs, mcs, fwr, frd;
    logic             sh1 = 1'b0;
    logic [2:0]       sh3 = 3'b0;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    // Slave model: data is only valid exactly RD_LAT cycles after the fp_rd pulse.
    always @(posedge clk) begin
        sh1 <= frd[0];
        sh3 <= {sh3[1:0], frd[1]};
    end
    assign frdat[0] = sh1    ? mem_val : 32'hbad0_bad0;
    assign frdat[1] = sh3[2] ? mem_val : 32'hbad0_bad0;

    mcs_io_bridge_fsm #(.BRG_BASE(32'hc000_0000), .RD_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .io_addr_strobe(io_addr_strobe),
        .io_read_strobe(io_read_strobe), .io_write_strobe(io_write_strobe),
        .io_byte_enable(io_byte_enable), .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(rdat[0]), .io_ready(rdy[0]), .fp_video_cs(vcs[0]), .fp_mmio_cs(mcs[0]),
        .fp_wr(fwr[0]), .fp_rd(frd[0]), .fp_addr(fad[0]), .fp_wr_data(fwd[0]), .fp_rd_data(frdat[0]));

    mcs_io_bridge_fsm #(.BRG_BASE(32'hc000_0000), .RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .io_addr_strobe(io_addr_strobe),
        .io_read_strobe(io_read_strobe), .io_write_strobe(io_write_strobe),
        .io_byte_enable(io_byte_enable), .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(rdat[1]), .io_ready(rdy[1]), .fp_video_cs(vcs[1]), .fp_mmio_cs(mcs[1]),
        .fp_wr(fwr[1]), .fp_rd(frd[1]), .fp_addr(fad[1]), .fp_wr_data(fwd[1]), .fp_rd_data(frdat[1]));

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdval;
        int          rdy1;
        int          rdy3;
        int          nwr;
        int          nrd;
        logic        video;
        logic [20:0] faddr;
        logic [31:0] fwd;
        logic        restrobe;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic any_out(input int d);
        return |{rdat[d], rdy[d], vcs[d], mcs[d], fwr[d], frd[d], fad[d], fwd[d]};
    endfunction

    // Called at a negedge; strobes are presented in cycle 0 and outputs sampled at negedges of cycles 1..12.
    task automatic run_txn(input vec_t v, input string tag);
        int first_rdy[2], nrdy[2], nwr_s[2], nrd_s[2], cs_s[2], both_s[2];
        logic vid_s[2];
        logic [20:0] ad_s[2];
        logic [31:0] wd_s[2], rd_s[2];
        int exp_rdy[2];
        exp_rdy[0] = v.rdy1;
        exp_rdy[1] = v.rdy3;
        for (int d = 0; d < 2; d++) begin
            first_rdy[d] = 0; nrdy[d] = 0; nwr_s[d] = 0; nrd_s[d] = 0;
            cs_s[d] = 0; both_s[d] = 0; vid_s[d] = 1'b0; ad_s[d] = '0; wd_s[d] = '0; rd_s[d] = '0;
        end
        io_address      = v.addr;
        io_write_data   = v.wdata;
        io_byte_enable  = v.be;
        io_write_strobe = v.wr;
        io_read_strobe  = v.rd;
        io_addr_strobe  = 1'b1;
        mem_val         = v.rdval;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rdy[d]) begin
                    nrdy[d]++;
                    if (first_rdy[d] == 0) first_rdy[d] = c;
                    rd_s[d] = rdat[d];
                end
                if (fwr[d]) begin nwr_s[d]++; wd_s[d] = fwd[d]; ad_s[d] = fad[d]; end
                if (frd[d]) begin nrd_s[d]++; ad_s[d] = fad[d]; end
                if (vcs[d] | mcs[d]) cs_s[d]++;
                if (vcs[d] & mcs[d]) both_s[d]++;
                if (vcs[d]) vid_s[d] = 1'b1;
            end
            if (c == 1) begin
                io_addr_strobe  = v.restrobe;
                io_write_strobe = v.restrobe;
                io_read_strobe  = 1'b0;
                if (v.restrobe) io_address = 32'hc000_0200;
            end else if (c == 2) begin
                io_addr_strobe  = 1'b0;
                io_write_strobe = 1'b0;
            end
        end
        if (v.rd && !v.wr) last_rd = (v.addr[31:24] == 8'hc0) ? v.rdval : 32'h0;
        for (int d = 0; d < 2; d++) begin
            string p;
            p = $sformatf("%s_d%0d", tag, d);
            chk({p, "_ready_cycle"}, 32'(first_rdy[d]), 32'(exp_rdy[d]));
            chk({p, "_ready_count"}, 32'(nrdy[d]), 32'd1);
            chk({p, "_wr_pulses"}, 32'(nwr_s[d]), 32'(v.nwr));
            chk({p, "_rd_pulses"}, 32'(nrd_s[d]), 32'(v.nrd));
            chk({p, "_cs_cycles"}, 32'(cs_s[d]), 32'(v.nwr + v.nrd));
            chk({p, "_cs_both"}, 32'(both_s[d]), 32'd0);
            chk({p, "_rdata"}, rd_s[d], last_rd);
            if (v.nwr + v.nrd > 0) begin
                chk({p, "_video_cs"}, 32'(vid_s[d]), 32'(v.video));
                chk({p, "_fp_addr"}, 32'(ad_s[d]), 32'(v.faddr));
            end
            if (v.nwr > 0) chk({p, "_wr_data"}, wd_s[d], v.fwd);
        end
    endtask

    initial begin
        logic rdy_seen;
        vec_t post;
        vecs[0] = '{1'b1, 1'b0, 32'hc000_0010, 32'hdead_beef, 4'hf, 32'h0, 2, 2, 1, 0, 1'b0, 21'h4, 32'hdead_beef, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hc080_0008, 32'h0, 4'hf, 32'h1234_5678, 3, 5, 0, 1, 1'b1, 21'h2, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0, 4'hf, 32'hffff_ffff, 1, 1, 0, 0, 1'b0, 21'h0, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h1234_5678, 32'ha5a5_a5a5, 4'hf, 32'h0, 1, 1, 0, 0, 1'b0, 21'h0, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'hc000_0020, 32'h1111_2222, 4'h0, 32'h0, 1, 1, 0, 0, 1'b0, 21'h0, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hc000_0040, 32'hcafe_f00d, 4'hf, 32'h9999_9999, 2, 2, 1, 0, 1'b0, 21'h10, 32'hcafe_f00d, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'hc07f_fffc, 32'h0, 4'hf, 32'ha5a5_5a5a, 3, 5, 0, 1, 1'b0, 21'h1f_ffff, 32'h0, 1'b0};
`ifdef BRG_BYTE_MERGE_EN
        vecs[7] = '{1'b1, 1'b0, 32'hc000_0100, 32'h1122_3344, 4'b0101, 32'haabb_ccdd, 4, 6, 1, 1, 1'b0, 21'h40, 32'haa22_cc44, 1'b0};
`else
        vecs[7] = '{1'b1, 1'b0, 32'hc000_0100, 32'h1122_3344, 4'b0101, 32'haabb_ccdd, 2, 2, 1, 0, 1'b0, 21'h40, 32'h1122_3344, 1'b0};
`endif
        vecs[8] = '{1'b1, 1'b0, 32'hc0ff_fff0, 32'h0, 4'hf, 32'h0, 2, 2, 1, 0, 1'b1, 21'h1f_fffc, 32'h0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, 32'hc0c0_0100, 32'h0, 4'hf, 32'h0bad_cafe, 3, 5, 0, 1, 1'b1, 21'h10_0040, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'hc000_0300, 32'h0, 4'hf, 32'h55aa_00ff, 3, 5, 0, 1, 1'b0, 21'hc0, 32'h0, 1'b1};
        post = '{1'b1, 1'b0, 32'hc000_0008, 32'h0f0f_f0f0, 4'hf, 32'h0, 2, 2, 1, 0, 1'b0, 21'h2, 32'h0f0f_f0f0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outs_d0", 32'(any_out(0)), 32'd0);
        chk("reset_outs_d1", 32'(any_out(1)), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Abort a read in cycle 1: io_read_data is nonzero beforehand, so the clear is observable.
        io_address     = 32'hc000_0004;
        io_read_strobe = 1'b1;
        io_addr_strobe = 1'b1;
        mem_val        = 32'h7777_0000;
        @(negedge clk);
        io_addr_strobe = 1'b0;
        io_read_strobe = 1'b0;
        chk("abort_rd_pulse_d0", 32'(frd[0]), 32'd1);
        chk("abort_rd_pulse_d1", 32'(frd[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_outs_d0", 32'(any_out(0)), 32'd0);
        chk("abort_outs_d1", 32'(any_out(1)), 32'd0);
        rdy_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            rdy_seen = rdy_seen | (|rdy) | (|frd) | (|fwr);
        end
        chk("abort_no_activity", 32'(rdy_seen), 32'd0);
        last_rd = 32'h0;
        reset_n = 1'b1;
        run_txn(post, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
